// File: rtl/alsu_op_sequencer.sv
// Command-side initiator for the ALSU: accepts one request, holds the ALSU drive
// registers for the pipeline latency, captures the result and returns it on a response channel.
module alsu_op_sequencer #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_A,
    input  logic [2:0] req_B,
    input  logic [2:0] req_opcode,
    input  logic       req_cin,
    input  logic       req_serial_in,
    input  logic       req_direction,
    input  logic       req_red_op_A,
    input  logic       req_red_op_B,
    input  logic       req_bypass_A,
    input  logic       req_bypass_B,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic [2:0] opcode,
    output logic       cin,
    output logic       serial_in,
    output logic       direction,
    output logic       red_op_A,
    output logic       red_op_B,
    output logic       bypass_A,
    output logic       bypass_B,
    input  logic [5:0] alsu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_data,
    output logic       rsp_invalid,
    output logic [7:0] txn_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       req_illegal;

    assign req_illegal = !req_bypass_A && !req_bypass_B &&
                         ((req_opcode >= 3'd6) ||
                          ((req_red_op_A || req_red_op_B) && (req_opcode >= 3'd2)));

    // Decoded from the state register; forced low while rst is high so nothing is accepted.
    assign req_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            A           <= '0;
            B           <= '0;
            opcode      <= '0;
            cin         <= 1'b0;
            serial_in   <= 1'b0;
            direction   <= 1'b0;
            red_op_A    <= 1'b0;
            red_op_B    <= 1'b0;
            bypass_A    <= 1'b0;
            bypass_B    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_invalid <= 1'b0;
            txn_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        A           <= req_A;
                        B           <= req_B;
                        opcode      <= req_opcode;
                        cin         <= req_cin;
                        serial_in   <= req_serial_in;
                        direction   <= req_direction;
                        red_op_A    <= req_red_op_A;
                        red_op_B    <= req_red_op_B;
                        bypass_A    <= req_bypass_A;
                        bypass_B    <= req_bypass_B;
                        rsp_invalid <= req_illegal;
                        wait_cnt    <= 4'(LATENCY);
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Capture one edge after the count hits zero: the ALSU needs an
                    // extra edge to sample the drive registers before its latency starts.
                    if (wait_cnt == 4'd0) begin
                        rsp_data  <= alsu_out;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 8'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_op_sequencer.sv
// Directed bench for alsu_op_sequencer with a behavioural two-stage ALSU model
// (input register + output register) closing the loop on alsu_out.
module tb_alsu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [2:0] req_A, req_B, req_opcode;
    logic       req_cin, req_serial_in, req_direction, req_red_op_A, req_red_op_B;
    logic       req_bypass_A, req_bypass_B;
    logic [2:0] A, B, opcode;
    logic       cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
    logic [5:0] alsu_out;
    logic       rsp_valid, rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_invalid;
    logic [7:0] txn_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_txn = 8'd0;

    always #5 clk = ~clk;

    alsu_op_sequencer #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_opcode(req_opcode),
        .req_cin(req_cin), .req_serial_in(req_serial_in), .req_direction(req_direction),
        .req_red_op_A(req_red_op_A), .req_red_op_B(req_red_op_B),
        .req_bypass_A(req_bypass_A), .req_bypass_B(req_bypass_B),
        .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B),
        .alsu_out(alsu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_invalid(rsp_invalid),
        .txn_count(txn_count)
    );

    // ALSU model: registered inputs, registered out; illegal combinations give 0.
    logic [2:0] a_r, b_r, op_r;
    logic       cin_r, sin_r, dir_r, ra_r, rb_r, ba_r, bb_r;
    logic       m_illegal;

    assign m_illegal = !ba_r && !bb_r && ((op_r >= 3'd6) || ((ra_r || rb_r) && op_r >= 3'd2));

    always @(posedge clk) begin
        if (rst) begin
            {a_r, b_r, op_r} <= '0;
            {cin_r, sin_r, dir_r, ra_r, rb_r, ba_r, bb_r} <= '0;
            alsu_out <= '0;
        end else begin
            {a_r, b_r, op_r} <= {A, B, opcode};
            {cin_r, sin_r, dir_r, ra_r, rb_r, ba_r, bb_r} <=
                {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};
            if (ba_r)           alsu_out <= {3'b0, a_r};
            else if (bb_r)      alsu_out <= {3'b0, b_r};
            else if (m_illegal) alsu_out <= '0;
            else begin
                case (op_r)
                    3'd0: alsu_out <= ra_r ? {5'b0, &a_r} : rb_r ? {5'b0, &b_r} : {3'b0, a_r & b_r};
                    3'd1: alsu_out <= ra_r ? {5'b0, ^a_r} : rb_r ? {5'b0, ^b_r} : {3'b0, a_r ^ b_r};
                    3'd2: alsu_out <= 6'(a_r) + 6'(b_r) + 6'(cin_r);
                    3'd3: alsu_out <= 6'(a_r) * 6'(b_r);
                    3'd4: alsu_out <= dir_r ? {alsu_out[4:0], sin_r} : {sin_r, alsu_out[5:1]};
                    default: alsu_out <= dir_r ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
                endcase
            end
        end
    end

    typedef struct {
        logic [2:0] a, b, op;
        logic       cin, sin, dir, ra, rb, ba, bb;
        logic [5:0] exp_data;
        logic       exp_inv;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_A = v.a; req_B = v.b; req_opcode = v.op;
        req_cin = v.cin; req_serial_in = v.sin; req_direction = v.dir;
        req_red_op_A = v.ra; req_red_op_B = v.rb;
        req_bypass_A = v.ba; req_bypass_B = v.bb;
    endtask

    // Issue one request from a negedge, expect the response 3 cycles after acceptance.
    task automatic run_txn(input vec_t v, input bit full);
        int n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (full) check("req_ready_before_issue", int'(req_ready), 1);
        drive(v);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (full) begin
            check("drive_A", int'(A), int'(v.a));
            check("drive_opcode", int'(opcode), int'(v.op));
            check("req_ready_in_wait", int'(req_ready), 0);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (full) begin
            check("rsp_latency", n, 3);
            check("rsp_data", int'(rsp_data), int'(v.exp_data));
            check("rsp_invalid", int'(rsp_invalid), int'(v.exp_inv));
        end else if (n >= 20) check("rsp_timeout", n, 3);
        @(negedge clk);
        exp_txn = exp_txn + 8'd1;
        if (full) begin
            check("rsp_valid_cleared", int'(rsp_valid), 0);
            check("txn_count", int'(txn_count), int'(exp_txn));
        end
    endtask

    vec_t vecs[9];
    vec_t v;
    int   seen;

    initial begin
        //           a     b     op    cin sin dir ra rb ba bb  data   inv
        vecs[0] = '{3'd5, 3'd6, 3'd2, 1, 0, 0, 0, 0, 0, 0, 6'd12, 0};
        vecs[1] = '{3'd7, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 6'd1,  0};
        vecs[2] = '{3'd1, 3'd2, 3'd2, 0, 0, 0, 0, 1, 0, 0, 6'd0,  1};
        vecs[3] = '{3'd3, 3'd1, 3'd6, 0, 0, 0, 0, 0, 1, 0, 6'd3,  0};
        vecs[4] = '{3'd5, 3'd3, 3'd1, 0, 0, 0, 0, 0, 0, 0, 6'd6,  0};
        vecs[5] = '{3'd3, 3'd5, 3'd3, 0, 0, 0, 0, 0, 0, 0, 6'd15, 0};
        vecs[6] = '{3'd2, 3'd2, 3'd7, 0, 0, 0, 0, 0, 0, 0, 6'd0,  1};
        vecs[7] = '{3'd1, 3'd4, 3'd7, 0, 0, 0, 0, 0, 0, 1, 6'd4,  0};
        vecs[8] = '{3'd7, 3'd0, 3'd1, 0, 0, 0, 1, 0, 0, 0, 6'd1,  0};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_drive", int'({A, B, opcode, cin, serial_in, direction,
                                     red_op_A, red_op_B, bypass_A, bypass_B}), 0);
        check("reset_rsp", int'({rsp_valid, rsp_data, rsp_invalid}), 0);
        check("reset_txn", int'(txn_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", int'(req_ready), 1);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], 1'b1);

        // Backpressure: response must hold and a stray request must be ignored.
        rsp_ready = 1'b0;
        v = '{3'd7, 3'd7, 3'd3, 0, 0, 0, 0, 0, 0, 0, 6'd49, 0};
        drive(v);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", int'(rsp_valid), 1);
            check("bp_rsp_data", int'(rsp_data), 49);
            check("bp_req_ready", int'(req_ready), 0);
            if (i == 4) begin
                req_A = 3'd1; req_opcode = 3'd0; req_valid = 1'b1;
            end else req_valid = 1'b0;
            @(negedge clk);
        end
        check("bp_drive_held", int'({A, opcode}), int'({3'd7, 3'd3}));
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_txn = exp_txn + 8'd1;
        check("bp_consumed", int'(rsp_valid), 0);
        check("bp_txn", int'(txn_count), int'(exp_txn));

        // Shift chain: bypass loads 5, then a right shift with serial_in=0 gives 2.
        v = '{3'd5, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 6'd5, 0};
        run_txn(v, 1'b1);
        v = '{3'd0, 3'd0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 6'd2, 0};
        run_txn(v, 1'b1);

        // Reset mid-WAIT abandons the transaction and clears the counter.
        drive(vecs[0]);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_txn = 8'd0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        check("midrst_no_rsp", seen, 0);
        check("midrst_txn", int'(txn_count), 0);
        check("midrst_idle", int'(req_ready), 1);

        // 256 completions wrap the counter back to 0.
        for (int i = 0; i < 255; i++) run_txn(vecs[i % 9], 1'b0);
        check("txn_255", int'(txn_count), 255);
        run_txn(vecs[0], 1'b0);
        check("txn_wrap", int'(txn_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
